// File: rtl/asrv32_dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder: FSM encoding,
// default geometry and the address range check.
package asrv32_dmem_responder_pkg;

   typedef enum logic [1:0] {
      DMEM_IDLE = 2'd0,
      DMEM_WAIT = 2'd1,
      DMEM_ACK  = 2'd2
   } dmem_state_t;

   localparam int DMEM_DEFAULT_ADDR_WIDTH  = 10;
   localparam int DMEM_DEFAULT_WAIT_STATES = 1;
   localparam int DMEM_MAX_WAIT_STATES     = 15;

   // A byte address is out of range when any bit above the word index is set.
   function automatic logic addr_out_of_range(input logic [31:0] addr, input int addr_width);
      return (addr >> (addr_width + 2)) != 32'd0;
   endfunction

endpackage

// File: rtl/asrv32_bytewrite_ram.sv
// Single-port synchronous data RAM: four byte-write enables, registered read
// that only updates on a read access. Contents are never reset.
module asrv32_bytewrite_ram #(
   parameter int    ADDR_WIDTH = 10,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   input  logic [3:0]            wmask,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (wmask[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/asrv32_dmem_responder.sv
// Wishbone-style data-memory responder: captures one strobed request, waits
// WAIT_STATES cycles, performs the RAM access and returns a one-cycle ack.
module asrv32_dmem_responder
   import asrv32_dmem_responder_pkg::*;
#(
   parameter int    ADDR_WIDTH  = DMEM_DEFAULT_ADDR_WIDTH,
   parameter int    WAIT_STATES = DMEM_DEFAULT_WAIT_STATES,
   parameter string INIT_FILE   = ""
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_stb_data,
   input  logic        i_wr_mem_en,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_store_data,
   input  logic [3:0]  i_wr_mask,
   output logic        o_ack_data,
   output logic [31:0] o_data_from_memory,
   output logic        o_err,
   output logic        o_busy
);

   localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);
   localparam bit         ZERO_WAIT  = (WAIT_STATES == 0);

   dmem_state_t           state;
   logic [3:0]            wait_cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [31:0]           data_q;
   logic [3:0]            mask_q;
   logic                  oor_q;
   logic                  rd_zero;

   logic                  req_oor;
   logic                  capture;
   logic                  access_now;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic                  acc_we;
   logic [31:0]           acc_data;
   logic [3:0]            acc_mask;
   logic                  acc_oor;
   logic [31:0]           ram_rdata;

   assign req_oor = addr_out_of_range(i_addr, ADDR_WIDTH);
   assign capture = (state == DMEM_IDLE) && i_stb_data;

   // With no wait states the access shares the capture edge, so the RAM is fed
   // straight from the request inputs; otherwise from the latched copy.
   assign acc_addr = ZERO_WAIT ? i_addr[ADDR_WIDTH+1:2] : addr_q;
   assign acc_we   = ZERO_WAIT ? i_wr_mem_en            : we_q;
   assign acc_data = ZERO_WAIT ? i_store_data           : data_q;
   assign acc_mask = ZERO_WAIT ? i_wr_mask              : mask_q;
   assign acc_oor  = ZERO_WAIT ? req_oor                : oor_q;

   assign access_now = !i_rst &&
                       (ZERO_WAIT ? capture
                                  : ((state == DMEM_WAIT) && (wait_cnt == 4'd1)));

   asrv32_bytewrite_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_ram (
      .clk   (i_clk),
      .en    (access_now && !acc_oor),
      .we    (acc_we),
      .addr  (acc_addr),
      .wdata (acc_data),
      .wmask (acc_mask),
      .rdata (ram_rdata)
   );

   // rd_zero remembers whether the last read was out of range (or reset came
   // since), so the held RAM word is replaced by zero on the output.
   assign o_data_from_memory = rd_zero ? 32'h0 : ram_rdata;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= DMEM_IDLE;
         wait_cnt   <= 4'd0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         data_q     <= 32'h0;
         mask_q     <= 4'h0;
         oor_q      <= 1'b0;
         rd_zero    <= 1'b1;
         o_ack_data <= 1'b0;
         o_err      <= 1'b0;
         o_busy     <= 1'b0;
      end else begin
         o_ack_data <= 1'b0;
         o_err      <= 1'b0;
         if (access_now && !acc_we) begin
            rd_zero <= acc_oor;
         end
         case (state)
            DMEM_IDLE: begin
               if (i_stb_data) begin
                  addr_q   <= i_addr[ADDR_WIDTH+1:2];
                  we_q     <= i_wr_mem_en;
                  data_q   <= i_store_data;
                  mask_q   <= i_wr_mask;
                  oor_q    <= req_oor;
                  wait_cnt <= WAIT_LOAD;
                  o_busy   <= 1'b1;
                  if (ZERO_WAIT) begin
                     state      <= DMEM_ACK;
                     o_ack_data <= 1'b1;
                     o_err      <= req_oor;
                  end else begin
                     state <= DMEM_WAIT;
                  end
               end
            end
            DMEM_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state      <= DMEM_ACK;
                  o_ack_data <= 1'b1;
                  o_err      <= oor_q;
               end
            end
            DMEM_ACK: begin
               state  <= DMEM_IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state  <= DMEM_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_asrv32_dmem_responder.sv
// Scoreboard bench: three responders (0, 1 and 3 wait states) share the request
// inputs; a monitor checks each one against a word-level memory model.
module tb_asrv32_dmem_responder;

   localparam int AW = 10;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
   } op_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_mem_en = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] store_data = 32'h0;
   logic [3:0]  wr_mask = 4'h0;
   logic [2:0]  stb = 3'b000;
   logic [2:0]  ack;
   logic [2:0]  err;
   logic [2:0]  busy;
   logic [31:0] rdata [3];

   int          checks = 0;
   int          failures = 0;
   op_t         sbq [3][$];
   logic [31:0] model [int];
   logic [31:0] last_rd [3];
   int          age [3];

   always #5 clk = ~clk;

   asrv32_dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
      .i_clk(clk), .i_rst(rst), .i_stb_data(stb[0]), .i_wr_mem_en(wr_mem_en),
      .i_addr(addr), .i_store_data(store_data), .i_wr_mask(wr_mask),
      .o_ack_data(ack[0]), .o_data_from_memory(rdata[0]), .o_err(err[0]), .o_busy(busy[0]));

   asrv32_dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(1), .INIT_FILE("")) u_dut1 (
      .i_clk(clk), .i_rst(rst), .i_stb_data(stb[1]), .i_wr_mem_en(wr_mem_en),
      .i_addr(addr), .i_store_data(store_data), .i_wr_mask(wr_mask),
      .o_ack_data(ack[1]), .o_data_from_memory(rdata[1]), .o_err(err[1]), .o_busy(busy[1]));

   asrv32_dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(3), .INIT_FILE("")) u_dut3 (
      .i_clk(clk), .i_rst(rst), .i_stb_data(stb[2]), .i_wr_mem_en(wr_mem_en),
      .i_addr(addr), .i_store_data(store_data), .i_wr_mask(wr_mask),
      .o_ack_data(ack[2]), .o_data_from_memory(rdata[2]), .o_err(err[2]), .o_busy(busy[2]));

   function automatic int ws_of(input int k);
      case (k)
         0:       return 0;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   task automatic check_output(input string name, input int k,
                               input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s inst=%0d ws=%0d t=%0t actual=%h expected=%h",
                  name, k, ws_of(k), $time, act, exp);
      end
   endtask

   // Monitor: ack timing is counted in falling edges since the strobe was raised.
   always @(negedge clk) begin
      op_t         op;
      logic        oor;
      int          key;
      logic [31:0] word_val;
      logic [31:0] exp_data;
      for (int k = 0; k < 3; k++) begin
         if (sbq[k].size() == 0) age[k] = 0;
         else                    age[k]++;
         if (rst) begin
            last_rd[k] = 32'h0;
            check_output("rst_ack",  k, 32'(ack[k]),  32'h0);
            check_output("rst_busy", k, 32'(busy[k]), 32'h0);
            check_output("rst_err",  k, 32'(err[k]),  32'h0);
            check_output("rst_data", k, rdata[k],     32'h0);
         end else if (sbq[k].size() != 0 && (ack[k] || age[k] > 40)) begin
            op       = sbq[k].pop_front();
            oor      = (op.addr >> (AW + 2)) != 32'h0;
            key      = k * 4096 + int'(op.addr[AW+1:2]);
            word_val = model.exists(key) ? model[key] : 32'h0;
            if (op.we) begin
               if (!oor) begin
                  for (int b = 0; b < 4; b++)
                     if (op.mask[b]) word_val[8*b +: 8] = op.data[8*b +: 8];
                  model[key] = word_val;
               end
               exp_data = last_rd[k];
            end else begin
               exp_data = oor ? 32'h0 : word_val;
            end
            check_output("ack_seen",    k, 32'(ack[k]),  32'h1);
            check_output("ack_latency", k, 32'(age[k]),  32'(2 + ws_of(k)));
            check_output("ack_err",     k, 32'(err[k]),  32'(oor));
            check_output("ack_data",    k, rdata[k],     exp_data);
            check_output("ack_busy",    k, 32'(busy[k]), 32'h1);
            last_rd[k] = exp_data;
            age[k]     = 0;
         end else begin
            check_output("spurious_ack", k, 32'(ack[k]),  32'h0);
            check_output("idle_err",     k, 32'(err[k]),  32'h0);
            check_output("busy",         k, 32'(busy[k]),
                         32'((sbq[k].size() != 0) && (age[k] >= 2)));
            check_output("held_data",    k, rdata[k],     last_rd[k]);
         end
      end
   end

   // Drives one request to the selected instances and releases each strobe
   // in the cycle its ack is seen.
   task automatic apply_stimulus(input logic we, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] m, input logic [2:0] sel,
                                 input bit change_addr, input logic [31:0] alt_addr,
                                 input bit do_reset);
      op_t op;
      @(posedge clk); #1;
      wr_mem_en  = we;
      addr       = a;
      store_data = d;
      wr_mask    = m;
      op.we = we; op.addr = a; op.data = d; op.mask = m;
      for (int k = 0; k < 3; k++)
         if (sel[k]) sbq[k].push_back(op);
      stb = sel;
      if (do_reset) begin
         @(posedge clk); #1;
         rst = 1'b1;
         stb = 3'b000;
         for (int k = 0; k < 3; k++) sbq[k].delete();
         @(posedge clk); #1;
         rst = 1'b0;
         return;
      end
      if (change_addr) begin
         @(posedge clk); #1;
         addr       = alt_addr;
         wr_mem_en  = ~we;
         store_data = ~d;
         wr_mask    = ~m;
      end
      for (int n = 0; n < 60 && stb != 3'b000; n++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++)
            if (ack[k]) stb[k] = 1'b0;
      end
      stb = 3'b000;
   endtask

   initial begin
      logic [31:0] a;
      logic        we;
      $display("[TB] start");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int w = 0; w < 16; w++)
         apply_stimulus(1'b1, 32'(w * 4), $urandom, 4'hF, 3'b111, 1'b0, 32'h0, 1'b0);

      apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h10, 32'h0,        4'h0, 3'b111, 1'b0, 32'h0, 1'b0);

      apply_stimulus(1'b1, 32'h20, 32'h11223344, 4'hF,    3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b1, 32'h20, 32'h0000AA00, 4'b0010, 3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h20, 32'h0,        4'h0,    3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b1, 32'h20, 32'hBBBB0000, 4'b1100, 3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h20, 32'h0,        4'h0,    3'b111, 1'b0, 32'h0, 1'b0);

      apply_stimulus(1'b1, 32'h24, 32'hCAFEF00D, 4'h0, 3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h24, 32'h0,        4'hF, 3'b111, 1'b0, 32'h0, 1'b0);

      apply_stimulus(1'b1, 32'h00001000, 32'h5A5A5A5A, 4'hF, 3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b1, 32'h00001010, 32'h12345678, 4'hF, 3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h00000000, 32'h0,        4'h0, 3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h00001000, 32'h0,        4'h0, 3'b111, 1'b0, 32'h0, 1'b0);

      apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 3'b111, 1'b1, 32'h20, 1'b0);

      apply_stimulus(1'b1, 32'h30, 32'h0BADC0DE, 4'hF, 3'b110, 1'b0, 32'h0, 1'b1);
      apply_stimulus(1'b0, 32'h30, 32'h0,        4'h0, 3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b1, 32'h34, 32'h600DF00D, 4'hF, 3'b111, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b0, 32'h34, 32'h0,        4'h0, 3'b111, 1'b0, 32'h0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         we = 1'($urandom_range(0, 1));
         a  = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
         apply_stimulus(we, a, $urandom, 4'($urandom_range(0, 15)), 3'b111, 1'b0, 32'h0, 1'b0);
      end

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
